bitmanip_exec_stage: RTL

Two-stage pipelined execution stage for the Zbb bit-manipulation subset of the 64-bit core. It sits between the issue/operand-read stage and writeback. It registers the issued operands and evaluates one of 16 operations. These are the `bitcounter`-class population count, the `zeroscounter`-class leading/trailing-zero count, and the logical, min/max, rotate and extension ops. The registered result is presented to writeback under a valid/ready handshake with full back-pressure and flush.

---
 rtl/bitmanip_exec_stage_if.sv | 29 ++
 rtl/bitmanip_exec_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bitmanip_exec_stage_if.sv
// Valid/ready bundle between issue, the bit-manipulation stage and writeback.
// Issue side drives in_*/out_ready (master); the stage receives them (slave).
interface bitmanip_exec_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic             in_word;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [4:0]       in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_rd;

    modport master (
        output in_valid, in_op, in_word, in_rs1, in_rs2, in_rd,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_word, in_rs1, in_rs2, in_rd,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd
    );
endinterface

// File: rtl/bitmanip_exec_stage.sv
// Two-stage Zbb execution stage: S1 holds operands, S2 holds the result.
// Ports: clk, rst_n (sync, active-low), flush, bus (slave handshake bundle).
module bitmanip_exec_stage #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    bitmanip_exec_stage_if.slave bus
);
    localparam logic [3:0] OP_CPOP  = 4'd0;
    localparam logic [3:0] OP_CLZ   = 4'd1;
    localparam logic [3:0] OP_CTZ   = 4'd2;
    localparam logic [3:0] OP_ANDN  = 4'd3;
    localparam logic [3:0] OP_ORN   = 4'd4;
    localparam logic [3:0] OP_XNOR  = 4'd5;
    localparam logic [3:0] OP_MIN   = 4'd6;
    localparam logic [3:0] OP_MAX   = 4'd7;
    localparam logic [3:0] OP_MINU  = 4'd8;
    localparam logic [3:0] OP_MAXU  = 4'd9;
    localparam logic [3:0] OP_ROL   = 4'd10;
    localparam logic [3:0] OP_ROR   = 4'd11;
    localparam logic [3:0] OP_SEXTB = 4'd12;
    localparam logic [3:0] OP_SEXTH = 4'd13;
    localparam logic [3:0] OP_ZEXTH = 4'd14;
    localparam logic [3:0] OP_ORCB  = 4'd15;

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic             r_s1_word;
    logic [WIDTH-1:0] r_s1_rs1;
    logic [WIDTH-1:0] r_s1_rs2;
    logic [4:0]       r_s1_rd;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic [4:0]       r_s2_rd;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_result;

    function automatic logic [6:0] f_cpop(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [6:0] f_clz(input logic [63:0] v);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 7'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] f_ctz(input logic [63:0] v);
        logic [6:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 7'd1;
            end
        end
        return n;
    endfunction

    assign w_s2_adv   = !r_s2_valid | bus.out_ready;
    assign w_in_ready = !flush & (!r_s1_valid | w_s2_adv);
    assign w_in_fire  = bus.in_valid & w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_s2_result;
    assign bus.out_rd     = r_s2_rd;

    // W-variants: zero the high half for cpop; for clz/ctz pad the unused
    // half with ones so a zero low word counts exactly 32.
    logic [63:0] w_cpop_src;
    logic [63:0] w_clz_src;
    logic [63:0] w_ctz_src;
    logic [6:0]  w_cpop;
    logic [6:0]  w_clz;
    logic [6:0]  w_ctz;

    assign w_cpop_src = r_s1_word ? {32'd0, r_s1_rs1[31:0]} : r_s1_rs1;
    assign w_clz_src  = r_s1_word ? {r_s1_rs1[31:0], 32'hFFFF_FFFF}
                                  : r_s1_rs1;
    assign w_ctz_src  = r_s1_word ? {32'hFFFF_FFFF, r_s1_rs1[31:0]}
                                  : r_s1_rs1;
    assign w_cpop     = f_cpop(w_cpop_src);
    assign w_clz      = f_clz(w_clz_src);
    assign w_ctz      = f_ctz(w_ctz_src);

    // Shifts by the full width yield zero, which covers a zero amount.
    logic [5:0]  w_sh;
    logic [4:0]  w_shw;
    logic [6:0]  w_sh_inv;
    logic [5:0]  w_shw_inv;
    logic [31:0] w_lo;
    logic [63:0] w_rol;
    logic [63:0] w_ror;
    logic [31:0] w_rolw;
    logic [31:0] w_rorw;

    assign w_sh      = r_s1_rs2[5:0];
    assign w_shw     = r_s1_rs2[4:0];
    assign w_sh_inv  = 7'd64 - {1'b0, w_sh};
    assign w_shw_inv = 6'd32 - {1'b0, w_shw};
    assign w_lo      = r_s1_rs1[31:0];
    assign w_rol     = (r_s1_rs1 << w_sh) | (r_s1_rs1 >> w_sh_inv);
    assign w_ror     = (r_s1_rs1 >> w_sh) | (r_s1_rs1 << w_sh_inv);
    assign w_rolw    = (w_lo << w_shw) | (w_lo >> w_shw_inv);
    assign w_rorw    = (w_lo >> w_shw) | (w_lo << w_shw_inv);

    logic        w_lt_s;
    logic        w_lt_u;
    logic [63:0] w_orcb;

    assign w_lt_s = $signed(r_s1_rs1) < $signed(r_s1_rs2);
    assign w_lt_u = r_s1_rs1 < r_s1_rs2;

    always_comb begin
        w_orcb = '0;
        for (int b = 0; b < 8; b++) begin
            w_orcb[b*8 +: 8] = {8{|r_s1_rs1[b*8 +: 8]}};
        end
    end

    always_comb begin
        w_result = '0;
        unique case (r_s1_op)
            OP_CPOP:  w_result = {57'd0, w_cpop};
            OP_CLZ:   w_result = {57'd0, w_clz};
            OP_CTZ:   w_result = {57'd0, w_ctz};
            OP_ANDN:  w_result = r_s1_rs1 & ~r_s1_rs2;
            OP_ORN:   w_result = r_s1_rs1 | ~r_s1_rs2;
            OP_XNOR:  w_result = ~(r_s1_rs1 ^ r_s1_rs2);
            // Ties fall to rs1 in all four compares.
            OP_MIN:   w_result = (w_lt_s || r_s1_rs1 == r_s1_rs2)
                                 ? r_s1_rs1 : r_s1_rs2;
            OP_MAX:   w_result = w_lt_s ? r_s1_rs2 : r_s1_rs1;
            OP_MINU:  w_result = (w_lt_u || r_s1_rs1 == r_s1_rs2)
                                 ? r_s1_rs1 : r_s1_rs2;
            OP_MAXU:  w_result = w_lt_u ? r_s1_rs2 : r_s1_rs1;
            OP_ROL:   w_result = r_s1_word ? {{32{w_rolw[31]}}, w_rolw}
                                           : w_rol;
            OP_ROR:   w_result = r_s1_word ? {{32{w_rorw[31]}}, w_rorw}
                                           : w_ror;
            OP_SEXTB: w_result = {{56{r_s1_rs1[7]}}, r_s1_rs1[7:0]};
            OP_SEXTH: w_result = {{48{r_s1_rs1[15]}}, r_s1_rs1[15:0]};
            OP_ZEXTH: w_result = {48'd0, r_s1_rs1[15:0]};
            OP_ORCB:  w_result = w_orcb;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_word   <= 1'b0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_rd     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_rd     <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                // Only load on a real op so an idle S2 keeps its data.
                if (r_s1_valid) begin
                    r_s2_result <= w_result;
                    r_s2_rd     <= r_s1_rd;
                end
            end
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_op   <= bus.in_op;
                r_s1_word <= bus.in_word;
                r_s1_rs1  <= bus.in_rs1;
                r_s1_rs2  <= bus.in_rs2;
                r_s1_rd   <= bus.in_rd;
            end
        end
    end
endmodule
